// File: rtl/per_input_port.sv
// Debounced input port with edge flags and level interrupt; PER_INPUT_PORT_IRQ_EN enables IE/irq.
// Pin-to-IN latency DEB_CYCLES+2 clocks; IFG one clock later; no backpressure, reads combinational.
module per_input_port #(
    parameter logic [7:0]  BASE_ADDR  = 8'h02,
    parameter int          N          = 8,
    parameter logic [15:0] DEB_CYCLES = 16'd50000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  pins,
    input  logic [7:0]    per_addr,
    input  logic [15:0]   per_din,
    input  logic          per_en,
    input  logic [1:0]    per_we,
    output logic [15:0]   per_dout,
    output logic          irq
);

    localparam logic [15:0] DEB_LAST = DEB_CYCLES - 16'd1;

    logic [N-1:0] sync1;
    logic [N-1:0] sync2;
    logic [N-1:0] deb;
    logic [N-1:0] deb_d;
    logic [N-1:0] ifg;
    logic [N-1:0] ie;
    logic [N-1:0] ies;
    logic [15:0]  cnt [N];

    logic [7:0]   offset;
    logic         hit;
    logic [15:0]  byte_mask;
    logic [N-1:0] wmask;
    logic [N-1:0] wdat;
    logic [N-1:0] ifg_set;
    logic [N-1:0] ifg_clr;
    logic [N-1:0] rdata;
    logic [15:0]  rd_word;
    logic         unused_bits;

    // Two-flop synchroniser on the raw pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pins;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb <= '0;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= 16'd0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (cnt[i] == DEB_LAST) begin
                        deb[i] <= sync2[i];
                        cnt[i] <= 16'd0;
                    end else begin
                        cnt[i] <= cnt[i] + 16'd1;
                    end
                end else begin
                    cnt[i] <= 16'd0;
                end
            end
        end
    end

    // deb_d lags deb by one clock, so the edge pulse lands the cycle after the change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_d <= '0;
        end else begin
            deb_d <= deb;
        end
    end

    assign ifg_set = ((deb & ~deb_d) & ~ies) | ((~deb & deb_d) & ies);

    assign offset    = per_addr - BASE_ADDR;
    assign hit       = per_en && (offset[7:2] == 6'd0);
    assign byte_mask = {{8{per_we[1]}}, {8{per_we[0]}}};
    assign wmask     = hit ? byte_mask[N-1:0] : '0;
    assign wdat      = per_din[N-1:0];
    assign ifg_clr   = (offset[1:0] == 2'd1) ? (wdat & wmask) : '0;

    // Set beats clear when both hit the same flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifg <= '0;
        end else begin
            ifg <= (ifg & ~ifg_clr) | ifg_set;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ies <= '0;
        end else if (offset[1:0] == 2'd3) begin
            ies <= (ies & ~wmask) | (wdat & wmask);
        end
    end

`ifdef PER_INPUT_PORT_IRQ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie <= '0;
        end else if (offset[1:0] == 2'd2) begin
            ie <= (ie & ~wmask) | (wdat & wmask);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= |(ifg & ie);
        end
    end
`else
    assign ie  = '0;
    assign irq = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        case (offset[1:0])
            2'd0: rdata = deb;
            2'd1: rdata = ifg;
            2'd2: rdata = ie;
            default: rdata = ies;
        endcase
        rd_word = 16'h0000;
        if (hit && (per_we == 2'b00) && !rst) begin
            rd_word[N-1:0] = rdata;
        end
    end

    assign per_dout = rd_word;

    assign unused_bits = ^{per_din, offset};

endmodule
